// File: rtl/instruction_encoder.sv
// RV32I instruction encoder: validates an encode request, packs the fields for
// the selected format and queues the word in a 2-entry FIFO.
module instruction_encoder (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  format,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instruction,
  output logic [1:0]  count,
  output logic        error_pulse,
  output logic [7:0]  error_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic        ready_en;
  logic [31:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count_q;
  logic        legal;
  logic [31:0] word;
  logic        fits12;
  logic        fits13;
  logic        fits21;
  logic        accept;
  logic        push;
  logic        pop;

  // An immediate fits N signed bits when every bit above N-1 copies the sign.
  assign fits12 = (imm[31:11] == {21{imm[31]}});
  assign fits13 = (imm[31:12] == {20{imm[31]}});
  assign fits21 = (imm[31:20] == {12{imm[31]}});

  always_comb begin
    legal = 1'b0;
    word  = NOP;
    case (format)
      FMT_R: begin
        legal = 1'b1;
        word  = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      FMT_I: begin
        legal = fits12;
        word  = {imm[11:0], rs1, funct3, rd, opcode};
      end
      FMT_S: begin
        legal = fits12;
        word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      end
      FMT_B: begin
        legal = fits13 && !imm[0];
        word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      end
      FMT_U: begin
        legal = (imm[11:0] == 12'h000);
        word  = {imm[31:12], rd, opcode};
      end
      FMT_J: begin
        legal = fits21 && !imm[0];
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      end
      default: begin
        legal = 1'b0;
        word  = NOP;
      end
    endcase
    if (opcode[1:0] != 2'b11) legal = 1'b0;
  end

  // ready_en keeps in_ready low until the first edge after reset release.
  assign in_ready    = ready_en && (count_q != 2'd2);
  assign out_valid   = (count_q != 2'd0);
  assign accept      = in_valid && in_ready;
  assign push        = accept && legal;
  assign pop         = out_valid && out_ready;
  assign count       = count_q;
  assign instruction = (count_q == 2'd0) ? NOP : mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_en    <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count_q     <= 2'd0;
      error_pulse <= 1'b0;
      error_count <= 8'd0;
    end else begin
      ready_en    <= 1'b1;
      error_pulse <= accept && !legal;
      if (accept && !legal && (error_count != 8'hFF)) error_count <= error_count + 8'd1;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= word;
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: directed vectors plus random
// traffic compared against a queue-based reference model.
module tb_instruction_encoder;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  format;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction;
  logic [1:0]  count;
  logic        error_pulse;
  logic [7:0]  error_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mq [$];
  bit          m_ready_en;
  bit          m_pulse;
  int          m_errs;

  always #5 clock = ~clock;

  instruction_encoder dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .format(format), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .instruction(instruction),
    .count(count), .error_pulse(error_pulse), .error_count(error_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_legal(input logic [2:0] f, input logic [6:0] op, input logic [31:0] im);
    int s;
    s = $signed(im);
    if (f > 3'd5 || op[1:0] != 2'b11) return 1'b0;
    case (f)
      3'd1, 3'd2: return (s >= -2048) && (s <= 2047);
      3'd3:       return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
      3'd4:       return (im % 4096) == 0;
      3'd5:       return (s >= -1048576) && (s <= 1048575) && (s % 2 == 0);
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] m_encode();
    case (format)
      3'd0: return {funct7, rs2, rs1, funct3, rd, opcode};
      3'd1: return {imm[11:0], rs1, funct3, rd, opcode};
      3'd2: return {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      3'd3: return {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      3'd4: return {imm[31:12], rd, opcode};
      default: return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
    endcase
  endfunction

  task automatic compare_all();
    chk("count",       {30'd0, count},       mq.size());
    chk("out_valid",   {31'd0, out_valid},   mq.size() != 0);
    chk("in_ready",    {31'd0, in_ready},    m_ready_en && (mq.size() != 2));
    chk("instruction", instruction,          (mq.size() != 0) ? mq[0] : 32'h0000_0013);
    chk("error_pulse", {31'd0, error_pulse}, m_pulse);
    chk("error_count", {24'd0, error_count}, m_errs);
  endtask

  // Called just after a rising edge: predicts the next edge, then checks.
  task automatic step();
    bit acc, pop, lg;
    logic [31:0] w;
    acc = in_valid && m_ready_en && (mq.size() != 2);
    pop = (mq.size() != 0) && out_ready;
    lg  = m_legal(format, opcode, imm);
    w   = m_encode();
    @(posedge clock);
    if (pop) void'(mq.pop_front());
    if (acc && lg) mq.push_back(w);
    m_pulse = acc && !lg;
    if (m_pulse && m_errs < 255) m_errs++;
    m_ready_en = 1'b1;
    #1;
    compare_all();
  endtask

  task automatic req(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                     input logic [4:0] s2, input logic [31:0] im);
    in_valid = 1'b1; format = f; opcode = op; funct3 = f3; funct7 = f7;
    rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    mq.delete();
    m_ready_en = 1'b0;
    m_pulse    = 1'b0;
    m_errs     = 0;
    compare_all();
    @(posedge clock);
    #1;
    reset_n  = 1'b1;
    in_valid = 1'b0;
    chk("ready_after_release", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic rand_req();
    int pick;
    logic [31:0] r;
    int bnd [12] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, 1048574,
                     1048576, -1048576, 7, 32'h0000_1000};
    r        = $urandom;
    in_valid = ($urandom_range(0, 9) < 7);
    format   = 3'($urandom_range(0, 7));
    opcode   = ($urandom_range(0, 9) < 9) ? {r[6:2], 2'b11} : r[6:0];
    funct3   = r[9:7];
    funct7   = r[16:10];
    rd       = r[21:17];
    rs1      = r[26:22];
    rs2      = r[31:27];
    pick     = $urandom_range(0, 5);
    case (pick)
      0: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      1: imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
      2: imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
      3: imm = $urandom & 32'hFFFF_F000;
      4: imm = $urandom;
      default: imm = bnd[$urandom_range(0, 11)];
    endcase
    out_ready = ($urandom_range(0, 9) < 7);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    format = 3'd0; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
    rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd0;
    mq.delete(); m_ready_en = 1'b0; m_pulse = 1'b0; m_errs = 0;
    #2;
    compare_all();
    do_reset();
    step();

    // Directed encodings
    out_ready = 1'b1;
    req(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);  step();
    chk("r_word", instruction, 32'h0020_81B3);
    req(3'd1, 7'h13, 3'd0, 7'h7F, 5'd1, 5'd0, 5'd9, 32'hFFFF_FFFF); step();
    chk("i_word", instruction, 32'hFFF0_0093);
    req(3'd3, 7'h63, 3'd0, 7'd0, 5'd7, 5'd1, 5'd2, 32'd8); step();
    chk("b_word", instruction, 32'h0020_8463);
    req(3'd5, 7'h6F, 3'd5, 7'd0, 5'd1, 5'd4, 5'd4, 32'd2048); step();
    chk("j_word", instruction, 32'h0010_00EF);
    in_valid = 1'b0; step();

    // Illegal request and saturating error count
    req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800); step();
    chk("ill_pulse", {31'd0, error_pulse}, 32'd1);
    chk("ill_count", {30'd0, count}, 32'd0);
    chk("ill_errs",  {24'd0, error_count}, 32'd1);
    in_valid = 1'b0; step();
    chk("ill_pulse_off", {31'd0, error_pulse}, 32'd0);
    for (int i = 0; i < 256; i++) begin
      req((i % 2 == 0) ? 3'd7 : 3'd0, (i % 2 == 0) ? 7'h33 : 7'h30,
          3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0);
      step();
    end
    in_valid = 1'b0; step();
    chk("err_sat", {24'd0, error_count}, 32'd255);

    // Back-pressure: third request held off, head stable, drain in order
    out_ready = 1'b0;
    req(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0); step();
    req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF); step();
    chk("bp_count", {30'd0, count}, 32'd2);
    chk("bp_ready", {31'd0, in_ready}, 32'd0);
    req(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048); step();
    chk("bp_head", instruction, 32'h0020_81B3);
    in_valid = 1'b0; out_ready = 1'b1; step();
    chk("bp_drain2", instruction, 32'hFFF0_0093);
    step();
    chk("bp_empty", instruction, 32'h0000_0013);

    // Steady push+pop at occupancy 1
    out_ready = 1'b0;
    req(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000); step();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req(3'd1, 7'h13, 3'd0, 7'd0, 5'(i), 5'd2, 5'd0, 32'(i * 3)); step();
      chk("pp_count", {30'd0, count}, 32'd1);
    end
    in_valid = 1'b0; step();

    // Reset with a full FIFO
    out_ready = 1'b0;
    req(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0); step(); step();
    chk("pre_rst_count", {30'd0, count}, 32'd2);
    do_reset();
    step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rand_req();
      step();
      if (i == 1500) begin
        do_reset();
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
